// File: rtl/packmem_rd_arbiter_pkg.sv
// rtl/packmem_rd_arbiter_pkg.sv - port IDs, BPF sizes and tag latency for the packet-memory read arbiter
// PACKMEM_ARB_PESSIMISTIC_EN selects a 2-cycle adapter latency (default 1).
package packmem_rd_arbiter_pkg;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam logic [1:0] BPF_W = 2'b00;
  localparam logic [1:0] BPF_H = 2'b01;
  localparam logic [1:0] BPF_B = 2'b10;

`ifdef PACKMEM_ARB_PESSIMISTIC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct packed {
    logic valid;
    logic owner;
  } tag_t;

endpackage

// File: rtl/packmem_rd_arbiter_rr_arb2.sv
// rtl/packmem_rd_arbiter_rr_arb2.sv - two-input round-robin arbiter with one-hot grant
module rr_arb2
  import packmem_rd_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last_q;
  logic last_d;

  always_comb begin
    gnt = 2'b00;
    if (!rst) begin
      if (req[PORT_A] && req[PORT_B]) begin
        // contention goes to whichever port did not win last
        if (last_q == PORT_B) gnt[PORT_A] = 1'b1;
        else                  gnt[PORT_B] = 1'b1;
      end else begin
        gnt = req;
      end
    end
    last_d = last_q;
    if (gnt[PORT_A])      last_d = PORT_A;
    else if (gnt[PORT_B]) last_d = PORT_B;
  end

  always_ff @(posedge clk) begin
    if (rst) last_q <= PORT_B;
    else     last_q <= last_d;
  end

endmodule

// File: rtl/packmem_rd_arbiter.sv
// rtl/packmem_rd_arbiter.sv - shares the packet-memory read path between CPU (A) and forwarder (B)
// Tag pipeline depth follows LAT, set by PACKMEM_ARB_PESSIMISTIC_EN.
module packmem_rd_arbiter
  import packmem_rd_arbiter_pkg::*;
#(
  parameter int PACKET_BYTE_ADDR_WIDTH = 12,
  parameter int CNT_WIDTH              = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              a_rd_en,
  input  logic [PACKET_BYTE_ADDR_WIDTH-1:0] a_byte_addr,
  input  logic [1:0]                        a_transfer_sz,
  output logic                              a_gnt,
  output logic [31:0]                       a_rd_data,
  output logic                              a_rd_valid,
  input  logic                              b_rd_en,
  input  logic [PACKET_BYTE_ADDR_WIDTH-1:0] b_byte_addr,
  input  logic [1:0]                        b_transfer_sz,
  output logic                              b_gnt,
  output logic [31:0]                       b_rd_data,
  output logic                              b_rd_valid,
  output logic [PACKET_BYTE_ADDR_WIDTH-1:0] byte_rd_addr,
  output logic [1:0]                        transfer_sz,
  output logic                              mem_rd_en,
  input  logic [31:0]                       resized_mem_data,
  output logic [CNT_WIDTH-1:0]              a_gnt_cnt,
  output logic [CNT_WIDTH-1:0]              b_gnt_cnt
);

  logic [1:0] gnt;

  rr_arb2 u_rr_arb2 (
    .clk (clk),
    .rst (rst),
    .req ({b_rd_en, a_rd_en}),
    .gnt (gnt)
  );

  assign a_gnt     = gnt[PORT_A];
  assign b_gnt     = gnt[PORT_B];
  assign mem_rd_en = a_gnt | b_gnt;

  always_comb begin
    byte_rd_addr = '0;
    transfer_sz  = '0;
    if (a_gnt) begin
      byte_rd_addr = a_byte_addr;
      transfer_sz  = a_transfer_sz;
    end else if (b_gnt) begin
      byte_rd_addr = b_byte_addr;
      transfer_sz  = b_transfer_sz;
    end
  end

  tag_t [LAT-1:0]     tag_q;
  tag_t [LAT-1:0]     tag_d;
  tag_t               tail;
  logic [31:0]        a_rd_data_q;
  logic [31:0]        a_rd_data_d;
  logic [31:0]        b_rd_data_q;
  logic [31:0]        b_rd_data_d;
  logic [CNT_WIDTH-1:0] a_gnt_cnt_q;
  logic [CNT_WIDTH-1:0] a_gnt_cnt_d;
  logic [CNT_WIDTH-1:0] b_gnt_cnt_q;
  logic [CNT_WIDTH-1:0] b_gnt_cnt_d;

  always_comb begin
    tag_d[0].valid = mem_rd_en;
    tag_d[0].owner = b_gnt ? PORT_B : PORT_A;
    for (int i = 1; i < LAT; i++) tag_d[i] = tag_q[i-1];
  end

  assign tail = tag_q[LAT-1];

  // Strobes are masked during reset so reads granted just before it never report.
  assign a_rd_valid = tail.valid & (tail.owner == PORT_A) & ~rst;
  assign b_rd_valid = tail.valid & (tail.owner == PORT_B) & ~rst;

  // Data passes straight through on the strobe cycle and is held afterwards.
  assign a_rd_data   = a_rd_valid ? resized_mem_data : a_rd_data_q;
  assign b_rd_data   = b_rd_valid ? resized_mem_data : b_rd_data_q;
  assign a_rd_data_d = a_rd_data;
  assign b_rd_data_d = b_rd_data;

  always_comb begin
    a_gnt_cnt_d = a_gnt_cnt_q;
    b_gnt_cnt_d = b_gnt_cnt_q;
    if (a_gnt && (a_gnt_cnt_q != '1)) a_gnt_cnt_d = a_gnt_cnt_q + CNT_WIDTH'(1);
    if (b_gnt && (b_gnt_cnt_q != '1)) b_gnt_cnt_d = b_gnt_cnt_q + CNT_WIDTH'(1);
  end

  assign a_gnt_cnt = a_gnt_cnt_q;
  assign b_gnt_cnt = b_gnt_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q       <= '0;
      a_rd_data_q <= '0;
      b_rd_data_q <= '0;
      a_gnt_cnt_q <= '0;
      b_gnt_cnt_q <= '0;
    end else begin
      tag_q       <= tag_d;
      a_rd_data_q <= a_rd_data_d;
      b_rd_data_q <= b_rd_data_d;
      a_gnt_cnt_q <= a_gnt_cnt_d;
      b_gnt_cnt_q <= b_gnt_cnt_d;
    end
  end

endmodule

// File: tb/tb_packmem_rd_arbiter.sv
// tb/tb_packmem_rd_arbiter.sv - randomized bench with a behavioural arbiter/adapter model
module tb_packmem_rd_arbiter;

`ifdef PACKMEM_ARB_PESSIMISTIC_EN
  localparam int M_LAT = 2;
`else
  localparam int M_LAT = 1;
`endif
  localparam int AW = 12;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          a_rd_en = 1'b0, b_rd_en = 1'b0;
  logic [AW-1:0] a_byte_addr = '0, b_byte_addr = '0;
  logic [1:0]    a_transfer_sz = '0, b_transfer_sz = '0;
  logic          a_gnt, b_gnt, a_rd_valid, b_rd_valid, mem_rd_en;
  logic [31:0]   a_rd_data, b_rd_data;
  logic [31:0]   resized_mem_data = '0;
  logic [AW-1:0] byte_rd_addr;
  logic [1:0]    transfer_sz;
  logic [CW-1:0] a_gnt_cnt, b_gnt_cnt;

  packmem_rd_arbiter #(.PACKET_BYTE_ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .a_rd_en(a_rd_en), .a_byte_addr(a_byte_addr), .a_transfer_sz(a_transfer_sz),
    .a_gnt(a_gnt), .a_rd_data(a_rd_data), .a_rd_valid(a_rd_valid),
    .b_rd_en(b_rd_en), .b_byte_addr(b_byte_addr), .b_transfer_sz(b_transfer_sz),
    .b_gnt(b_gnt), .b_rd_data(b_rd_data), .b_rd_valid(b_rd_valid),
    .byte_rd_addr(byte_rd_addr), .transfer_sz(transfer_sz), .mem_rd_en(mem_rd_en),
    .resized_mem_data(resized_mem_data), .a_gnt_cnt(a_gnt_cnt), .b_gnt_cnt(b_gnt_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  int          cyc = 0;
  bit          chk_en = 0;
  int          m_last = 1;
  int          m_cnt[2];
  logic [31:0] m_held[2];
  bit          due_v[8];
  int          due_o[8];
  logic [31:0] due_w[8];

  function automatic logic [7:0] mbyte(input logic [AW-1:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a, input logic [1:0] sz);
    case (sz)
      2'b00:   return {mbyte(a), mbyte(a + 12'd1), mbyte(a + 12'd2), mbyte(a + 12'd3)};
      2'b01:   return {16'h0, mbyte(a), mbyte(a + 12'd1)};
      default: return {24'h0, mbyte(a)};
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic ae, input logic [AW-1:0] aa, input logic [1:0] as,
                      input logic be, input logic [AW-1:0] ba, input logic [1:0] bs);
    int slot;
    int g;
    int nslot;
    bit ev[2];
    logic [AW-1:0] eaddr;
    logic [1:0] esz;
    slot = cyc % 8;
    @(posedge clk);
    #1;
    rst = r;
    a_rd_en = ae; a_byte_addr = aa; a_transfer_sz = as;
    b_rd_en = be; b_byte_addr = ba; b_transfer_sz = bs;
    resized_mem_data = due_v[slot] ? due_w[slot] : $urandom;
    #3;
    g = -1;
    if (!r) begin
      if (ae && be) g = (m_last == 1) ? 0 : 1;
      else if (ae)  g = 0;
      else if (be)  g = 1;
    end
    eaddr = (g == 0) ? aa : (g == 1) ? ba : '0;
    esz   = (g == 0) ? as : (g == 1) ? bs : 2'b00;
    for (int p = 0; p < 2; p++) ev[p] = !r && due_v[slot] && (due_o[slot] == p);
    if (chk_en) begin
      check("a_gnt", 32'(a_gnt), 32'(g == 0));
      check("b_gnt", 32'(b_gnt), 32'(g == 1));
      check("mem_rd_en", 32'(mem_rd_en), 32'(g >= 0));
      check("byte_rd_addr", 32'(byte_rd_addr), 32'(eaddr));
      check("transfer_sz", 32'(transfer_sz), 32'(esz));
      check("a_rd_valid", 32'(a_rd_valid), 32'(ev[0]));
      check("b_rd_valid", 32'(b_rd_valid), 32'(ev[1]));
      check("a_rd_data", a_rd_data, ev[0] ? due_w[slot] : m_held[0]);
      check("b_rd_data", b_rd_data, ev[1] ? due_w[slot] : m_held[1]);
      check("a_gnt_cnt", 32'(a_gnt_cnt), 32'(m_cnt[0]));
      check("b_gnt_cnt", 32'(b_gnt_cnt), 32'(m_cnt[1]));
    end
    for (int p = 0; p < 2; p++) if (ev[p]) m_held[p] = due_w[slot];
    due_v[slot] = 0;
    if (r) begin
      for (int i = 0; i < 8; i++) due_v[i] = 0;
      m_held[0] = '0; m_held[1] = '0;
      m_cnt[0] = 0; m_cnt[1] = 0;
      m_last = 1;
      chk_en = 1;
    end else if (g >= 0) begin
      m_last = g;
      if (m_cnt[g] < (1 << CW) - 1) m_cnt[g]++;
      nslot = (cyc + M_LAT) % 8;
      due_v[nslot] = 1;
      due_o[nslot] = g;
      due_w[nslot] = mem_word(eaddr, esz);
    end
    cyc++;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, 2'b00, 1'b0, '0, 2'b00);
  endtask

  initial begin
    step(1'b1, 1'b0, '0, 2'b00, 1'b0, '0, 2'b00);
    check("reset a_gnt_cnt", 32'(a_gnt_cnt), 32'h0);
    check("reset b_rd_valid", 32'(b_rd_valid), 32'h0);

    // single A word read
    step(1'b0, 1'b1, 12'h010, 2'b00, 1'b0, '0, 2'b00);
    check("s1 a_gnt", 32'(a_gnt), 32'h1);
    check("s1 addr", 32'(byte_rd_addr), 32'h010);
    idle(); idle();
    check("s1 a_rd_data", a_rd_data, 32'h4A4B4849);

    // both ports contend for 8 cycles
    step(1'b1, 1'b0, '0, 2'b00, 1'b0, '0, 2'b00);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 12'(i * 4), 2'b00, 1'b1, 12'(i * 4 + 2), 2'b01);
      if (i == 0) check("s2 first grant A", 32'({a_gnt, b_gnt}), 32'h2);
    end
    idle(); idle();
    check("s2 a_gnt_cnt", 32'(a_gnt_cnt), 32'h4);
    check("s2 b_gnt_cnt", 32'(b_gnt_cnt), 32'h4);

    // B back-to-back bytes
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, 2'b00, 1'b1, 12'(3 + i), 2'b10);
    idle(); idle(); idle();
    check("s3 b_rd_data", b_rd_data, 32'h0000005C);

    // reset right after a grant
    step(1'b0, 1'b1, 12'h020, 2'b01, 1'b0, '0, 2'b00);
    step(1'b1, 1'b0, '0, 2'b00, 1'b0, '0, 2'b00);
    idle(); idle();
    check("s4 a_gnt_cnt", 32'(a_gnt_cnt), 32'h0);
    check("s4 a_rd_data", a_rd_data, 32'h0);

    // saturation
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 12'(i), 2'b10, 1'b0, '0, 2'b00);
    idle();
    check("s5 a_gnt_cnt sat", 32'(a_gnt_cnt), 32'hF);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 63) == 0),
           ($urandom_range(0, 9) < 6), 12'($urandom), 2'($urandom_range(0, 2)),
           ($urandom_range(0, 9) < 6), 12'($urandom), 2'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
